// File: rtl/up_down_dir_ctrl.sv
// Direction control for the up/down counter: the button is synchronised, debounced and
// edge-detected into a direction toggle. Define UP_DOWN_DIR_CTRL_AUTO_REVERSE_EN to add
// limit-based ping-pong reversal driven by the count_in feedback.
module up_down_dir_ctrl #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned MAX_VAL   = 15,
  parameter int unsigned MIN_VAL   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_in,
  input  logic [WIDTH-1:0] count_in,
  output logic             up_down,
  output logic             btn_pulse,
  output logic             dir_change
);

  // state      | meaning
  // IDLE       | button released and stable
  // PRESS_DB   | btn_s high, counting stable samples before accepting the press
  // HELD       | press accepted, waiting for release
  // RELEASE_DB | btn_s low, counting stable samples before accepting the release
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  localparam logic [7:0]       DB_LAST = 8'(DB_CYCLES - 1);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);

  logic       sync1_q, sync2_q;
  logic       btn_s;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       press;
  logic       limit_hit;
  logic       toggle;
  logic       up_down_q, up_down_d;
  logic       pulse_q;
  logic       dir_change_q;

  assign btn_s = sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // With DB_LAST==0 a single high/low sample is enough, so the debounce states are skipped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          if (DB_LAST == 8'd0) begin
            state_d = HELD;
            cnt_d   = 8'd0;
            press   = 1'b1;
          end else begin
            state_d = PRESS_DB;
            cnt_d   = 8'd1;
          end
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = 8'd0;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          if (DB_LAST == 8'd0) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            state_d = RELEASE_DB;
            cnt_d   = 8'd1;
          end
        end
      end
      RELEASE_DB: begin
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = 8'd0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef UP_DOWN_DIR_CTRL_AUTO_REVERSE_EN
  assign limit_hit = up_down_q ? (count_in == MAX_W) : (count_in == MIN_W);
`else
  logic unused_cfg;
  assign unused_cfg = ^{count_in, MAX_W, MIN_W};
  assign limit_hit  = 1'b0;
`endif

  // A limit hit and an accepted press on the same edge must flip the direction only once.
  assign toggle    = press | limit_hit;
  assign up_down_d = up_down_q ^ toggle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_down_q    <= 1'b0;
      pulse_q      <= 1'b0;
      dir_change_q <= 1'b0;
    end else begin
      up_down_q    <= up_down_d;
      pulse_q      <= press;
      dir_change_q <= toggle;
    end
  end

  assign up_down    = up_down_q;
  assign btn_pulse  = pulse_q;
  assign dir_change = dir_change_q;

endmodule

// File: tb/tb_up_down_dir_ctrl.sv
// Table-driven bench for up_down_dir_ctrl; expectations follow UP_DOWN_DIR_CTRL_AUTO_REVERSE_EN.
module tb_up_down_dir_ctrl;

`ifdef UP_DOWN_DIR_CTRL_AUTO_REVERSE_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       btn_in;
  logic [3:0] count_in;
  logic       up_down;
  logic       btn_pulse;
  logic       dir_change;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       btn;
    logic [3:0] cnt;
    logic       ud;
    logic       p;
    logic       dc;
  } vec_t;

  vec_t vecs[$];

  up_down_dir_ctrl #(
    .WIDTH(4), .DB_CYCLES(4), .MAX_VAL(15), .MIN_VAL(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .count_in(count_in),
    .up_down(up_down),
    .btn_pulse(btn_pulse),
    .dir_change(dir_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic b, input logic [3:0] c, input logic u, input logic p,
                     input logic d);
    vec_t v;
    v.btn = b; v.cnt = c; v.ud = u; v.p = p; v.dc = d;
    vecs.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic u, input logic p, input logic d);
    chk({tag, " up_down"}, up_down, u);
    chk({tag, " btn_pulse"}, btn_pulse, p);
    chk({tag, " dir_change"}, dir_change, d);
  endtask

  initial begin
    logic [3:0] ar_cnt [8];
    logic       ar_ud  [8];
    logic       ar_dc  [8];
    logic       bnc    [6];

    ar_cnt = '{4'd13, 4'd14, 4'd15, 4'd8, 4'd2, 4'd1, 4'd0, 4'd8};
    ar_ud  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ar_dc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bnc    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // btn held through reset: press accepted on the 6th edge after release
    for (int i = 1; i <= 8; i++) add(1'b1, 4'd7, i >= 6, i == 6, i == 6);
    for (int i = 0; i < 8; i++)  add(1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
    // clean 10-cycle press
    for (int i = 1; i <= 10; i++) add(1'b1, 4'd7, i < 6, i == 6, i == 6);
    for (int i = 0; i < 8; i++)   add(1'b0, 4'd7, 1'b0, 1'b0, 1'b0);
    // bounce rejection
    for (int i = 0; i < 6; i++) add(bnc[i], 4'd7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) add(1'b0, 4'd7, 1'b0, 1'b0, 1'b0);
    // release glitch while held
    for (int i = 1; i <= 22; i++) add(i <= 12 || i >= 15, 4'd7, i >= 6, i == 6, i == 6);
    for (int i = 0; i < 8; i++)   add(1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
    // limit feedback
    for (int i = 0; i < 8; i++)
      add(1'b0, ar_cnt[i], AR ? ar_ud[i] : 1'b1, 1'b0, AR ? ar_dc[i] : 1'b0);
    // press completes on the same edge as the upper limit
    for (int i = 1; i <= 8; i++)
      add(1'b1, (i == 6) ? 4'd15 : 4'd7, i < 6, i == 6, i == 6);
    for (int i = 0; i < 8; i++) add(1'b0, 4'd7, 1'b0, 1'b0, 1'b0);

    reset    = 1'b1;
    btn_in   = 1'b1;
    count_in = 4'd7;
    #8;
    chk_all("reset_a", 1'b0, 1'b0, 1'b0);
    #10;
    chk_all("reset_b", 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      btn_in   = vecs[i].btn;
      count_in = vecs[i].cnt;
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", i), vecs[i].ud, vecs[i].p, vecs[i].dc);
      @(negedge clk);
    end

    // reset in the middle of a press debounce must not produce a pulse
    btn_in = 1'b1;
    repeat (4) @(negedge clk);
    reset  = 1'b1;
    btn_in = 1'b0;
    #1;
    chk_all("abort_in_reset", 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("abort%0d", i), 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
